alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
Bit-serial sequencer that computes one WIDTH-bit ALU operation by driving a single 1-bit ALU_Slice over WIDTH cycles, LSB first.
- Supports AND, OR, ADD, SUB and SLT, using the same 6-bit funct encoding as the slice.
- Owns the operand shift registers, the carry flop, the bit counter and the start/done handshake.
- Area-minimal alternative to a ripple array. Sits between the decode stage and the register write-back.

Parameters:
WIDTH, 32, operand/result width in bits (>=2).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  request pulse; sampled only in IDLE.
a  in  WIDTH  operand A; captured when start is accepted.
b  in  WIDTH  operand B; captured when start is accepted.
Signal  in  6  funct code: AND=36, OR=37, ADD=32, SUB=34, SLT=42; captured when start is accepted.
busy  out  1  high from acceptance until return to IDLE.
done  out  1  one-cycle pulse; result is valid.
result  out  WIDTH  registered result; holds until the next done.
zero  out  1  (result == 0); registered with result.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- On rst: state=IDLE; busy=0, done=0, result=0, zero=1; counter, carry and shift registers = 0. Reset mid-RUN aborts the operation, and no done is produced.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If start=1 at edge E0: latch a, b, Signal.
  - Set inv=1 for SUB or SLT, else 0; carry=inv; cnt=0; go to RUN. busy=1 from E0.
- RUN:
  - Each cycle, drive the slice with a_sh[0], b_sh[0], carry, inv and the latched Signal.
  - At each edge: a_sh and b_sh shift right; the slice out shifts into the MSB of res_sh; carry<=cout; cnt++.
  - On the bit where cnt==WIDTH-1, also capture carry-in (cin_msb) and cout (cout_msb).
  - After WIDTH RUN edges (edge E_WIDTH), go to DONE.
- DONE:
  - Lasts one cycle, with done=1.
  - result and zero are loaded at the entering edge E_WIDTH.
  - Next edge: go to IDLE, and busy=0 at that edge.
  - Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH cycles after acceptance.
  - Back-to-back throughput: one operation per WIDTH+2 cycles.
- SLT: performs a subtract.
  - ovf = cin_msb ^ cout_msb.
  - lt = res_sh[WIDTH-1] ^ ovf.
  - result = {WIDTH-1 zeros, lt}.
- Arithmetic is two's-complement, modulo 2^WIDTH. Carry-out is discarded, except for SLT and the optional overflow output.
- Unlisted Signal values produce the ADD result (slice default), with inv=0.
- start while busy (RUN or DONE) is ignored and not queued. Operand and Signal changes during RUN have no effect.
- start=1 in the same cycle as rst=1: rst wins.

Optional Feature:
Macro ALU_SERIAL_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0, loaded at E_WIDTH alongside result.
  - overflow = cin_msb ^ cout_msb for ADD and SUB; 0 for AND, OR and SLT.
- Undefined: no port and no cin_msb/cout_msb logic beyond what SLT requires. Behaviour is otherwise identical.

Decomposition:
- Shared header alu_defs.vh (included):
  - funct constants FUNCT_AND/OR/ADD/SUB/SLT.
  - FSM state encodings ST_IDLE/ST_RUN/ST_DONE (2 bits).
- One sub-module: a single instance of the existing ALU_Slice (ports a, b, cin, inv, Signal, cout, out) as the datapath.
- FSM, counter ($clog2(WIDTH) bits) and shift registers live in alu_serial_seq.

Test Plan:
1. ADD a=5, b=7, start at cycle 0 -> done high exactly 32 cycles later; result=0x0000000C, zero=0; busy low one cycle after done.
2. SUB a=3, b=5 -> result=0xFFFFFFFE. SUB a=b=0x1234 -> result=0, zero=1.
3. SLT, three cases:
   - a=0xFFFFFFFF, b=1 -> result=1.
   - a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow case).
   - a=b -> result=0.
4. AND a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000. OR on the same operands -> 0xFFF0FFF0. Unlisted Signal=0 with a=1, b=1 -> result=2.
5. Handshake and reset:
   - Assert start again at cycles 5 and 32 of an op -> ignored; exactly one done; result unchanged by the second operands.
   - rst at cycle 10 -> busy=0, result=0, no done; a new start at cycle 12 completes normally.
6. With ALU_SERIAL_OVF_EN:
   - ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1.
   - SUB 0x80000000-1 -> overflow=1.
   - ADD 1+1 -> overflow=0.

Source files
------------

// File: rtl/alu_serial_seq_pkg.sv
// Shared funct codes, FSM encodings and decode helper for the bit-serial ALU.
// Used by alu_serial_seq and its ALU_Slice datapath.
package alu_serial_seq_pkg;

    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_SLT = 6'd42;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // SUB and SLT both run as a + ~b + 1.
    function automatic logic needs_invert(input logic [5:0] funct);
        return (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_seq_slice.sv
// One-bit ALU slice: AND/OR of the raw bits, or a full-adder sum with optional
// inversion of b. Unlisted funct codes fall through to the sum.
module ALU_Slice
    import alu_serial_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       inv,
    input  logic [5:0] Signal,
    output logic       cout,
    output logic       out
);

    logic b_eff;
    logic sum;

    always_comb begin
        b_eff = b ^ inv;
        sum   = a ^ b_eff ^ cin;
        cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
        case (Signal)
            FUNCT_AND:                       out = a & b;
            FUNCT_OR:                        out = a | b;
            FUNCT_ADD, FUNCT_SUB, FUNCT_SLT: out = sum;
            default:                         out = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one ALU_Slice for WIDTH cycles, LSB first.
// Define ALU_SERIAL_OVF_EN to add a signed-overflow output for ADD/SUB.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [5:0]       funct;
    logic             inv;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             slice_out;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;
    logic             msb_ovf;
    logic             lt;

    ALU_Slice u_slice (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry),
        .inv    (inv),
        .Signal (funct),
        .cout   (slice_cout),
        .out    (slice_out)
    );

    // On the MSB step, carry holds the carry-in and slice_cout the carry-out.
    assign res_next = {slice_out, res_sh};
    assign msb_ovf  = carry ^ slice_cout;
    assign lt       = slice_out ^ msb_ovf;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            funct  <= '0;
            inv    <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        funct <= Signal;
                        inv   <= needs_invert(Signal);
                        carry <= needs_invert(Signal);
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_next[WIDTH-1:1];
                    carry  <= slice_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= ST_DONE;
                        if (funct == FUNCT_SLT) begin
                            result <= {{(WIDTH-1){1'b0}}, lt};
                            zero   <= ~lt;
                        end else begin
                            result <= res_next;
                            zero   <= (res_next == '0);
                        end
`ifdef ALU_SERIAL_OVF_EN
                        overflow <= ((funct == FUNCT_ADD) || (funct == FUNCT_SUB)) && msb_ovf;
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq: directed vector table, handshake/reset sequences
// and randomized ops against a reference model. Honours ALU_SERIAL_OVF_EN.
module tb_alu_serial_seq;
    import alu_serial_seq_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   Signal;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
`ifdef ALU_SERIAL_OVF_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .Signal (Signal),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
`ifdef ALU_SERIAL_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        logic [W-1:0] exp_res;
        logic         exp_zero;
        logic         exp_ovf;
    } vec_t;

    function automatic logic [W-1:0] model_result(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        case (f)
            FUNCT_AND: return x & y;
            FUNCT_OR:  return x | y;
            FUNCT_SUB: return x - y;
            FUNCT_SLT: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            default:   return x + y;
        endcase
    endfunction

    // Signed overflow: operands that agree in sign (after negating b for SUB) but a result that does not.
    function automatic logic model_ovf(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        if (f == FUNCT_ADD) begin
            r = x + y;
            return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end else if (f == FUNCT_SUB) begin
            r = x - y;
            return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        return 1'b0;
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op, scrambles the inputs during RUN, and reports what came out at done.
    task automatic apply_stimulus(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic z, output int lat);
        @(negedge clk);
        a = x; b = y; Signal = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; Signal = 6'($urandom);
        check_output("busy_after_accept", W'(busy), W'(1));
        lat = 0; r = '0; z = 1'b0;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i; r = result; z = zero;
                break;
            end
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            check_output("busy_after_done", W'(busy), W'(0));
            check_output("done_single_cycle", W'(done), W'(0));
        end
    endtask

    vec_t         vecs[15];
    logic [W-1:0] got_r;
    logic         got_z;
    int           lat;
    int           done_count;
    logic [W-1:0] got;
    logic [5:0]   fset[6];
    logic [W-1:0] corners[5];
    logic [5:0]   rf;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        vecs[0]  = '{FUNCT_ADD, 32'h5,        32'h7,        32'h0000000C, 1'b0, 1'b0};
        vecs[1]  = '{FUNCT_SUB, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{FUNCT_SUB, 32'h1234,     32'h1234,     32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{FUNCT_SLT, 32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0, 1'b0};
        vecs[4]  = '{FUNCT_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
        vecs[5]  = '{FUNCT_SLT, 32'h1234,     32'h1234,     32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{FUNCT_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        vecs[7]  = '{FUNCT_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[8]  = '{FUNCT_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[9]  = '{6'd0,      32'h1,        32'h1,        32'h00000002, 1'b0, 1'b0};
        vecs[10] = '{FUNCT_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1};
        vecs[11] = '{FUNCT_SUB, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[12] = '{FUNCT_ADD, 32'h1,        32'h1,        32'h00000002, 1'b0, 1'b0};
        vecs[13] = '{FUNCT_ADD, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{FUNCT_AND, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; Signal = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", W'(busy), W'(0));
        check_output("reset_done", W'(done), W'(0));
        check_output("reset_result", result, W'(0));
        check_output("reset_zero", W'(zero), W'(1));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].funct, vecs[i].opa, vecs[i].opb, got_r, got_z, lat);
            check_output($sformatf("vec%0d_latency", i), W'(lat), W'(W));
            check_output($sformatf("vec%0d_result", i), got_r, vecs[i].exp_res);
            check_output($sformatf("vec%0d_zero", i), W'(got_z), W'(vecs[i].exp_zero));
`ifdef ALU_SERIAL_OVF_EN
            check_output($sformatf("vec%0d_overflow", i), W'(overflow), W'(vecs[i].exp_ovf));
`endif
        end

        // Restarts at cycle 5 (RUN) and cycle 32 (DONE) must be dropped.
        @(negedge clk);
        a = 32'd5; b = 32'd7; Signal = FUNCT_ADD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'd100; b = 32'd200;
        done_count = 0; got = '0;
        for (int cyc = 1; cyc <= W + 8; cyc++) begin
            start = (cyc == 6) || (cyc == W + 1);
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                done_count++;
                got = result;
            end
        end
        check_output("ignored_start_done_count", W'(done_count), W'(1));
        check_output("ignored_start_result", got, W'(12));
        check_output("ignored_start_idle", W'(busy), W'(0));

        // Reset in the middle of RUN aborts without a done.
        @(negedge clk);
        a = 32'd9; b = 32'd4; Signal = FUNCT_SUB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_count = 0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (done) done_count++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("midrun_reset_busy", W'(busy), W'(0));
        check_output("midrun_reset_result", result, W'(0));
        check_output("midrun_reset_zero", W'(zero), W'(1));
        for (int cyc = 0; cyc < W + 2; cyc++) begin
            @(posedge clk); #1;
            if (done) done_count++;
        end
        check_output("midrun_reset_no_done", W'(done_count), W'(0));
        apply_stimulus(FUNCT_SUB, 32'd9, 32'd4, got_r, got_z, lat);
        check_output("after_reset_latency", W'(lat), W'(W));
        check_output("after_reset_result", got_r, W'(5));

        // start coinciding with rst is lost, not remembered.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 32'd1; b = 32'd1; Signal = FUNCT_ADD;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check_output("rst_beats_start", W'(busy), W'(0));
        @(posedge clk); #1;
        check_output("rst_start_not_queued", W'(busy), W'(0));

        fset[0] = FUNCT_AND; fset[1] = FUNCT_OR; fset[2] = FUNCT_ADD;
        fset[3] = FUNCT_SUB; fset[4] = FUNCT_SLT; fset[5] = 6'd0;
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h7FFFFFFF; corners[4] = 32'h80000000;
        for (int n = 0; n < 40; n++) begin
            rf = fset[$urandom_range(0, 5)];
            if (rf == 6'd0) rf = 6'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            apply_stimulus(rf, ra, rb, got_r, got_z, lat);
            check_output($sformatf("rand%0d_latency", n), W'(lat), W'(W));
            check_output($sformatf("rand%0d_result f=%0d a=%08h b=%08h", n, rf, ra, rb), got_r, model_result(rf, ra, rb));
            check_output($sformatf("rand%0d_zero", n), W'(got_z), W'(model_result(rf, ra, rb) == '0));
`ifdef ALU_SERIAL_OVF_EN
            if (rf == FUNCT_ADD || rf == FUNCT_SUB || rf == FUNCT_AND || rf == FUNCT_OR || rf == FUNCT_SLT)
                check_output($sformatf("rand%0d_overflow", n), W'(overflow), W'(model_ovf(rf, ra, rb)));
`else
            if (model_ovf(rf, ra, rb) && rf == FUNCT_ADD)
                check_output($sformatf("rand%0d_ovf_wrap", n), got_r, ra + rb);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
